// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - multi-cycle restoring divider, one quotient bit per clock (optional DIV_SIGNED_EN)
module seq_divider #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;   // partial remainder
    logic [WIDTH-1:0] dvd_q, dvd_d;   // dividend shifting out, quotient shifting in
    logic [WIDTH-1:0] dsr_q, dsr_d;   // latched divisor (magnitude)
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rmd_q, rmd_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH:0]   rem_shift;
    logic [WIDTH+1:0] trial;
    logic             trial_ok;
    logic [WIDTH-1:0] rem_step;
    logic [WIDTH-1:0] quo_step;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [WIDTH-1:0] quo_final;
    logic [WIDTH-1:0] rmd_final;

`ifdef DIV_SIGNED_EN
    logic qneg_q, qneg_d;   // quotient must be negated on completion
    logic rneg_q, rneg_d;   // remainder follows the dividend sign
`endif

    // One restoring step: shift in the next dividend bit and try subtracting the divisor.
    // The trial is kept two bits wider so that the top two bits are 00 exactly when it fits.
    always_comb begin
        rem_shift = {rem_q, dvd_q[WIDTH-1]};
        trial     = {1'b0, rem_shift} - {2'b00, dsr_q};
        trial_ok  = (trial[WIDTH+1:WIDTH] == 2'b00);
        rem_step  = trial_ok ? trial[WIDTH-1:0] : rem_shift[WIDTH-1:0];
        quo_step  = {dvd_q[WIDTH-2:0], trial_ok};
    end

`ifdef DIV_SIGNED_EN
    // Operand magnitudes for the unsigned core and sign fixup of the final step's result.
    always_comb begin
        mag_a     = dividend[WIDTH-1] ? (~dividend + 1'b1) : dividend;
        mag_b     = divisor[WIDTH-1]  ? (~divisor + 1'b1)  : divisor;
        quo_final = qneg_q ? (~quo_step + 1'b1) : quo_step;
        rmd_final = rneg_q ? (~rem_step + 1'b1) : rem_step;
    end
`else
    // Unsigned build: operands and results pass straight through.
    always_comb begin
        mag_a     = dividend;
        mag_b     = divisor;
        quo_final = quo_step;
        rmd_final = rem_step;
    end
`endif

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            dvd_q   <= '0;
            dsr_q   <= '0;
            quo_q   <= '0;
            rmd_q   <= '0;
            dbz_q   <= 1'b0;
`ifdef DIV_SIGNED_EN
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            dvd_q   <= dvd_d;
            dsr_q   <= dsr_d;
            quo_q   <= quo_d;
            rmd_q   <= rmd_d;
            dbz_q   <= dbz_d;
`ifdef DIV_SIGNED_EN
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
`endif
        end
    end

    // Next-state logic: accept in IDLE, iterate WIDTH steps in CALC, hold result in DONE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        dvd_d   = dvd_q;
        dsr_d   = dsr_q;
        quo_d   = quo_q;
        rmd_d   = rmd_q;
        dbz_d   = dbz_q;
`ifdef DIV_SIGNED_EN
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    dvd_d = mag_a;
                    dsr_d = mag_b;
                    rem_d = '0;
                    cnt_d = '0;
`ifdef DIV_SIGNED_EN
                    qneg_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
                    rneg_d = dividend[WIDTH-1];
`endif
                    if (divisor == '0) begin
                        // Zero divisor skips the iteration entirely.
                        quo_d   = '1;
                        rmd_d   = dividend;
                        dbz_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                rem_d = rem_step;
                dvd_d = quo_step;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_STEP) begin
                    quo_d   = quo_final;
                    rmd_d   = rmd_final;
                    dbz_d   = 1'b0;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign in_ready    = (state_q == S_IDLE);
    assign out_valid   = (state_q == S_DONE);
    assign quotient    = quo_q;
    assign remainder   = rmd_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - self-checking bench for seq_divider against an arithmetic reference model
module tb_seq_divider;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int vectors = 0;
    int miscompares = 0;

    seq_divider #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .dividend   (dividend),
        .divisor    (divisor),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input string what, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s %s: observed %0h expected %0h", tag, what, obs, exp);
        end
    endtask

    // Reference: plain division of the operands as numbers.
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] q, output logic [W-1:0] r, output logic z);
        int sa, sb, tq, tr;
        if (b == 0) begin
            q = '1;
            r = a;
            z = 1'b1;
        end else begin
`ifdef DIV_SIGNED_EN
            sa = int'($signed(a));
            sb = int'($signed(b));
`else
            sa = int'(a);
            sb = int'(b);
`endif
            tq = sa / sb;
            tr = sa % sb;
            q  = tq[W-1:0];
            r  = tr[W-1:0];
            z  = 1'b0;
        end
    endtask

    task automatic run(input string tag, input logic [W-1:0] a, input logic [W-1:0] b, input int stall);
        logic [W-1:0] eq, er;
        logic         ez;
        int           k;
        model(a, b, eq, er, ez);
        out_ready = (stall == 0);
        k = 0;
        while (in_ready !== 1'b1 && k < 40) begin
            @(posedge clk); #1;
            k++;
        end
        chk(tag, "in_ready before accept", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk); #1;
        in_valid = 1'b0;
        dividend = W'($urandom);
        divisor  = W'($urandom);
        k = 0;
        while (out_valid !== 1'b1 && k < 40) begin
            @(posedge clk); #1;
            dividend = W'($urandom);
            divisor  = W'($urandom);
            k++;
        end
        chk(tag, "latency", k, (b == 0) ? 32'd0 : W);
        chk(tag, "quotient", {24'd0, quotient}, {24'd0, eq});
        chk(tag, "remainder", {24'd0, remainder}, {24'd0, er});
        chk(tag, "div_by_zero", {31'd0, div_by_zero}, {31'd0, ez});
        chk(tag, "in_ready while valid", {31'd0, in_ready}, 32'd0);
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            chk(tag, "stall out_valid", {31'd0, out_valid}, 32'd1);
            chk(tag, "stall in_ready", {31'd0, in_ready}, 32'd0);
            chk(tag, "stall quotient", {24'd0, quotient}, {24'd0, eq});
            chk(tag, "stall remainder", {24'd0, remainder}, {24'd0, er});
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk(tag, "out_valid after handoff", {31'd0, out_valid}, 32'd0);
        chk(tag, "in_ready after handoff", {31'd0, in_ready}, 32'd1);
        chk(tag, "quotient held", {24'd0, quotient}, {24'd0, eq});
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        int           seen;

        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset", "in_ready", {31'd0, in_ready}, 32'd1);
        chk("reset", "out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset", "quotient", {24'd0, quotient}, 32'd0);
        chk("reset", "remainder", {24'd0, remainder}, 32'd0);
        chk("reset", "div_by_zero", {31'd0, div_by_zero}, 32'd0);
        rst_n = 1'b1;

        run("100/7", 8'd100, 8'd7, 0);
        run("255/1", 8'd255, 8'd1, 0);
        run("3/10", 8'd3, 8'd10, 0);
        run("5/0", 8'd5, 8'd0, 0);
        run("200/13 stall", 8'd200, 8'd13, 5);

        // Abort 77/3 with reset on the fourth CALC edge.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        dividend  = 8'd77;
        divisor   = 8'd3;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("abort", "in_ready", {31'd0, in_ready}, 32'd1);
        chk("abort", "out_valid", {31'd0, out_valid}, 32'd0);
        chk("abort", "quotient", {24'd0, quotient}, 32'd0);
        chk("abort", "remainder", {24'd0, remainder}, 32'd0);
        chk("abort", "div_by_zero", {31'd0, div_by_zero}, 32'd0);
        seen = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) seen++;
        end
        chk("abort", "result emitted", seen, 32'd0);
        run("9/4", 8'd9, 8'd4, 0);

        run("max/max", 8'd255, 8'd255, 0);
        run("4/9", 8'd4, 8'd9, 0);
        run("0/5", 8'd0, 8'd5, 0);
        run("F9/02", 8'hF9, 8'h02, 0);
        run("80/FF", 8'h80, 8'hFF, 0);
        run("07/FE", 8'h07, 8'hFE, 0);
        run("80/00", 8'h80, 8'h00, 1);

        for (int n = 0; n < 40; n++) begin
            ra = W'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
            run("random", ra, rb, $urandom_range(0, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
